mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (dsp = 0, host = 1).
// Alternates grants on ties and caps a burst at MAX_BURST accesses when the other side is waiting.
module mem_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 14,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  state_t     r_state;
  logic       r_last;
  logic [3:0] r_cnt;
  logic       r_rvalid0, r_rvalid1;

  logic w_acc0, w_acc1, w_burst_end;

  assign gnt0        = (r_state == GRANT0);
  assign gnt1        = (r_state == GRANT1);
  assign w_acc0      = gnt0 & req0;
  assign w_acc1      = gnt1 & req1;
  assign w_burst_end = (r_cnt == LAST_CNT);

  assign mem_cs   = w_acc0 | w_acc1;
  assign mem_we   = (w_acc0 & we0) | (w_acc1 & we1);
  assign mem_addr = gnt1 ? addr1  : addr0;
  assign mem_din  = gnt1 ? wdata1 : wdata0;
  assign rdata    = mem_dout;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;

  // r_last starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 4'd0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_acc0 & ~we0;
      r_rvalid1 <= w_acc1 & ~we1;
      case (r_state)
        IDLE: begin
          r_cnt <= 4'd0;
          if (req0 && (!req1 || r_last)) begin
            r_state <= GRANT0;
            r_last  <= 1'b0;
          end else if (req1) begin
            r_state <= GRANT1;
            r_last  <= 1'b1;
          end
        end
        GRANT0: begin
          if (!req0) begin
            r_cnt   <= 4'd0;
            r_state <= req1 ? GRANT1 : IDLE;
            if (req1) r_last <= 1'b1;
          end else if (w_burst_end) begin
            // Full burst: hand over only if the other side is waiting.
            r_cnt <= 4'd0;
            if (req1) begin
              r_state <= GRANT1;
              r_last  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        GRANT1: begin
          if (!req1) begin
            r_cnt   <= 4'd0;
            r_state <= req0 ? GRANT0 : IDLE;
            if (req0) r_last <= 1'b0;
          end else if (w_burst_end) begin
            r_cnt <= 4'd0;
            if (req0) begin
              r_state <= GRANT0;
              r_last  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 14;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_din, mem_dout;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_cs, mem_we;
  logic [DATA_W-1:0] mem [64];

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout      <= mem[mem_addr];
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    nxt(); nxt();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    nxt(); smp();
    checks++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got=%b exp=00", {rvalid0, rvalid1}); end
    checks++; if ({mem_cs, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem got=%b exp=00", {mem_cs, mem_we}); end
  endtask

  // Both requests already high at release: requester 0 wins the first tie.
  task automatic test_tie();
    we0 = 0; we1 = 1; addr0 = 6'h03; addr1 = 6'h2A; wdata1 = 14'h1234;
    nxt(); rstn = 1'b0;
    smp();
    checks++; if (gnt0 !== 1'b0) begin fails++; $display("FAIL tie_pre_gnt0 got=%b exp=0", gnt0); end
    nxt(); smp();
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL tie_gnt0 got=%b exp=1", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin fails++; $display("FAIL tie_gnt1 got=%b exp=0", gnt1); end
  endtask

  // Continues from cycle 0 of the tie grant with both requests held.
  task automatic test_burst();
    logic o0, prev0;
    prev0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      o0 = ((i / 4) % 2) == 0;
      checks++; if ({gnt0, gnt1} !== {o0, ~o0}) begin fails++; $display("FAIL burst_gnt c%0d got=%b exp=%b", i, {gnt0, gnt1}, {o0, ~o0}); end
      checks++; if ({mem_cs, mem_we} !== {1'b1, ~o0}) begin fails++; $display("FAIL burst_cs_we c%0d got=%b exp=%b", i, {mem_cs, mem_we}, {1'b1, ~o0}); end
      checks++; if (mem_addr !== (o0 ? 6'h03 : 6'h2A)) begin fails++; $display("FAIL burst_addr c%0d got=%h", i, mem_addr); end
      if (!o0) begin
        checks++; if (mem_din !== 14'h1234) begin fails++; $display("FAIL burst_din c%0d got=%h exp=1234", i, mem_din); end
      end
      checks++; if (rvalid0 !== (i > 0 && prev0)) begin fails++; $display("FAIL burst_rvalid0 c%0d got=%b exp=%b", i, rvalid0, (i > 0 && prev0)); end
      checks++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL burst_rvalid1 c%0d got=%b exp=0", i, rvalid1); end
      prev0 = o0;
      nxt(); smp();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 6'h15; wdata0 = 14'h2A5C;
    nxt(); smp();
    checks++; if ({gnt0, mem_cs, mem_we} !== 3'b111) begin fails++; $display("FAIL wr_ctl got=%b exp=111", {gnt0, mem_cs, mem_we}); end
    checks++; if (mem_addr !== 6'h15 || mem_din !== 14'h2A5C) begin fails++; $display("FAIL wr_bus got=%h/%h exp=15/2a5c", mem_addr, mem_din); end
    nxt(); we0 = 0; smp();
    checks++; if ({mem_cs, mem_we, rvalid0} !== 3'b100) begin fails++; $display("FAIL rd_ctl got=%b exp=100", {mem_cs, mem_we, rvalid0}); end
    nxt(); req0 = 0; smp();
    checks++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL rd_rvalid0 got=%b exp=1", rvalid0); end
    checks++; if (rdata !== 14'h2A5C) begin fails++; $display("FAIL rd_data got=%h exp=2a5c", rdata); end
    checks++; if (rvalid1 !== 1'b0) begin fails++; $display("FAIL rd_rvalid1 got=%b exp=0", rvalid1); end
    nxt(); smp();
    checks++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL rd_rvalid0_clr got=%b exp=0", rvalid0); end
  endtask

  // Host alone keeps the grant past MAX_BURST; a brief req0 blip mid-count is ignored.
  task automatic test_no_release();
    int pulses;
    do_reset();
    req1 = 1; we1 = 0; addr1 = 6'h2A; pulses = 0;
    nxt(); smp();
    for (int i = 0; i < 10; i++) begin
      if (mem_cs) pulses++;
      checks++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL norel_gnt c%0d got=%b exp=01", i, {gnt0, gnt1}); end
      checks++; if (rvalid1 !== (i > 0)) begin fails++; $display("FAIL norel_rvalid1 c%0d got=%b exp=%b", i, rvalid1, (i > 0)); end
      nxt();
      req0 = (i == 4);
      if (i == 9) req1 = 0;
      smp();
    end
    checks++; if (pulses !== 10) begin fails++; $display("FAIL norel_pulses got=%0d exp=10", pulses); end
    checks++; if ({mem_cs, rvalid1, gnt1} !== 3'b011) begin fails++; $display("FAIL norel_tail got=%b exp=011", {mem_cs, rvalid1, gnt1}); end
    checks++; if (mem_addr !== 6'h2A) begin fails++; $display("FAIL norel_addr got=%h exp=2a", mem_addr); end
  endtask

  task automatic test_idle_bubble();
    do_reset();
    req0 = 1; we0 = 1;
    nxt(); smp();
    checks++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL bub_gnt0 got=%b exp=1", gnt0); end
    nxt(); req0 = 0; smp();
    checks++; if ({gnt0, mem_cs, mem_we} !== 3'b100) begin fails++; $display("FAIL bub_drop got=%b exp=100", {gnt0, mem_cs, mem_we}); end
    nxt(); req1 = 1; smp();
    checks++; if ({gnt0, gnt1, mem_cs, mem_we} !== 4'b0000) begin fails++; $display("FAIL bub_idle got=%b exp=0000", {gnt0, gnt1, mem_cs, mem_we}); end
    nxt(); smp();
    checks++; if ({gnt1, mem_cs} !== 2'b11) begin fails++; $display("FAIL bub_gnt1 got=%b exp=11", {gnt1, mem_cs}); end
    // Requester 1 drops while 0 waits: direct handover without an idle cycle.
    nxt(); req1 = 0; req0 = 1; smp();
    nxt(); smp();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL bub_handover got=%b exp=10", {gnt0, gnt1}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 6'h15;
    nxt(); nxt(); smp();
    checks++; if ({gnt0, rvalid0, mem_cs} !== 3'b111) begin fails++; $display("FAIL ares_pre got=%b exp=111", {gnt0, rvalid0, mem_cs}); end
    req1 = 1;
    #2 rstn = 1'b1;
    #1;
    checks++; if ({gnt0, rvalid0, mem_cs} !== 3'b000) begin fails++; $display("FAIL ares_async got=%b exp=000", {gnt0, rvalid0, mem_cs}); end
    nxt(); rstn = 1'b0; smp();
    checks++; if ({gnt0, gnt1, rvalid0} !== 3'b000) begin fails++; $display("FAIL ares_idle got=%b exp=000", {gnt0, gnt1, rvalid0}); end
    nxt(); smp();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL ares_tie got=%b exp=10", {gnt0, gnt1}); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_burst();
    test_write_read();
    test_no_release();
    test_idle_bubble();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
